// File: rtl/multicycle_control_fsm_if.sv
// rtl/multicycle_control_fsm_if.sv - control bundle between IR/memory and the sequencer
// master: sequencer side; slave: datapath side.
interface multicycle_control_fsm_if #(
   parameter int RET_W = 32
);
   logic [6:0]       opcode;
   logic             zero;
   logic             mem_ready;
   logic             PCwrite;
   logic             IRwrite;
   logic             IorD;
   logic             Memread;
   logic             Memwrite;
   logic             Regwrite;
   logic             Branch;
   logic             Jump;
   logic             PCsrc;
   logic [1:0]       ALUsrcA;
   logic [1:0]       ALUsrcB;
   logic [1:0]       ResultSrc;
   logic [1:0]       ALUop;
   logic             illegal;
   logic             trap;
   logic [3:0]       state;
   logic [RET_W-1:0] retired;

   modport master (
      input  opcode, zero, mem_ready,
      output PCwrite, IRwrite, IorD, Memread, Memwrite, Regwrite, Branch, Jump,
             PCsrc, ALUsrcA, ALUsrcB, ResultSrc, ALUop, illegal, trap, state, retired
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  PCwrite, IRwrite, IorD, Memread, Memwrite, Regwrite, Branch, Jump,
             PCsrc, ALUsrcA, ALUsrcB, ResultSrc, ALUop, illegal, trap, state, retired
   );
endinterface

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multi-cycle RV32I subset sequencer with memory timeout trap
// Moore control decode per state, gated by mem_ready/zero/opcode where the datapath needs it.
module multicycle_control_fsm #(
   parameter int TIMEOUT = 16,
   parameter int RET_W   = 32
) (
   input logic                      clk,
   input logic                      rst,
   multicycle_control_fsm_if.master bus
);
   localparam logic [3:0] S_RST      = 4'd0;
   localparam logic [3:0] S_FETCH    = 4'd1;
   localparam logic [3:0] S_DECODE   = 4'd2;
   localparam logic [3:0] S_MEMADR   = 4'd3;
   localparam logic [3:0] S_MEMREAD  = 4'd4;
   localparam logic [3:0] S_MEMWB    = 4'd5;
   localparam logic [3:0] S_MEMWRITE = 4'd6;
   localparam logic [3:0] S_EXEC_R   = 4'd7;
   localparam logic [3:0] S_EXEC_I   = 4'd8;
   localparam logic [3:0] S_ALUWB    = 4'd9;
   localparam logic [3:0] S_BRANCH   = 4'd10;
   localparam logic [3:0] S_JAL      = 4'd11;
   localparam logic [3:0] S_JALR     = 4'd12;
   localparam logic [3:0] S_TRAP     = 4'd15;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;

   localparam int              WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;

   logic [3:0]        state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [RET_W-1:0]  retired_q, retired_d;
   logic              mem_state;
   logic              retire;

   always_comb begin
      state_d   = state_q;
      mem_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
      retire    = 1'b0;
      case (state_q)
         S_RST:      state_d = S_FETCH;
         S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (bus.opcode)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_R:              state_d = S_EXEC_R;
               OP_I:              state_d = S_EXEC_I;
               OP_BR:             state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               OP_JALR:           state_d = S_JALR;
               default:           state_d = S_FETCH;
            endcase
         end
         S_MEMADR:   state_d = (bus.opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
         S_MEMWRITE: begin
            if (bus.mem_ready) begin
               state_d = S_FETCH;
               retire  = 1'b1;
            end
         end
         S_EXEC_R, S_EXEC_I: state_d = S_ALUWB;
         S_MEMWB, S_ALUWB, S_BRANCH, S_JAL, S_JALR: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_TRAP:     state_d = S_TRAP;
         default:    state_d = S_RST;
      endcase

      // A ready response in the last allowed cycle beats the timeout.
      if ((TIMEOUT > 0) && mem_state && !bus.mem_ready && (wait_cnt_q == WAIT_LAST))
         state_d = S_TRAP;

      wait_cnt_d = (mem_state && !bus.mem_ready && (state_d == state_q))
                   ? wait_cnt_q + WAIT_W'(1) : '0;
      retired_d  = retire ? retired_q + RET_W'(1) : retired_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_RST;
         wait_cnt_q <= '0;
         retired_q  <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         retired_q  <= retired_d;
      end
   end

   always_comb begin
      bus.PCwrite   = 1'b0;
      bus.IRwrite   = 1'b0;
      bus.IorD      = 1'b0;
      bus.Memread   = 1'b0;
      bus.Memwrite  = 1'b0;
      bus.Regwrite  = 1'b0;
      bus.Branch    = 1'b0;
      bus.Jump      = 1'b0;
      bus.PCsrc     = 1'b0;
      bus.ALUsrcA   = 2'b00;
      bus.ALUsrcB   = 2'b00;
      bus.ResultSrc = 2'b00;
      bus.ALUop     = 2'b00;
      bus.illegal   = 1'b0;
      bus.trap      = 1'b0;
      case (state_q)
         S_FETCH: begin
            bus.Memread = 1'b1;
            bus.ALUsrcB = 2'b10;
            bus.IRwrite = bus.mem_ready;
            bus.PCwrite = bus.mem_ready;
         end
         S_DECODE: begin
            // Branch/JAL target computed from OldPC + imm while the opcode resolves.
            bus.ALUsrcA = 2'b01;
            bus.ALUsrcB = 2'b01;
            case (bus.opcode)
               OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR: bus.illegal = 1'b0;
               default: bus.illegal = 1'b1;
            endcase
         end
         S_MEMADR: begin
            bus.ALUsrcA = 2'b10;
            bus.ALUsrcB = 2'b01;
         end
         S_MEMREAD: begin
            bus.Memread = 1'b1;
            bus.IorD    = 1'b1;
         end
         S_MEMWB: begin
            bus.Regwrite  = 1'b1;
            bus.ResultSrc = 2'b01;
         end
         S_MEMWRITE: begin
            bus.Memwrite = 1'b1;
            bus.IorD     = 1'b1;
         end
         S_EXEC_R: begin
            bus.ALUsrcA = 2'b10;
            bus.ALUop   = 2'b10;
         end
         S_EXEC_I: begin
            bus.ALUsrcA = 2'b10;
            bus.ALUsrcB = 2'b01;
            bus.ALUop   = 2'b10;
         end
         S_ALUWB: bus.Regwrite = 1'b1;
         S_BRANCH: begin
            bus.Branch  = 1'b1;
            bus.ALUsrcA = 2'b10;
            bus.ALUop   = 2'b01;
            bus.PCsrc   = 1'b1;
            bus.PCwrite = bus.zero;
         end
         S_JAL: begin
            bus.Jump      = 1'b1;
            bus.PCwrite   = 1'b1;
            bus.PCsrc     = 1'b1;
            bus.Regwrite  = 1'b1;
            bus.ResultSrc = 2'b10;
         end
         S_JALR: begin
            bus.Jump      = 1'b1;
            bus.ALUsrcA   = 2'b10;
            bus.ALUsrcB   = 2'b01;
            bus.PCwrite   = 1'b1;
            bus.Regwrite  = 1'b1;
            bus.ResultSrc = 2'b10;
         end
         S_TRAP:  bus.trap = 1'b1;
         default: bus.trap = 1'b0;
      endcase
   end

   assign bus.state   = state_q;
   assign bus.retired = retired_q;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - directed-vector bench for multicycle_control_fsm
module tb_multicycle_control_fsm;
   logic clk;
   logic rst;
   int   pass_cnt;
   int   total_cnt;

   multicycle_control_fsm_if #(.RET_W(32)) bus ();

   multicycle_control_fsm #(.TIMEOUT(16), .RET_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [22:0] ctrl_vec;
   assign ctrl_vec = {bus.PCwrite, bus.IRwrite, bus.IorD, bus.Memread, bus.Memwrite,
                      bus.Regwrite, bus.Branch, bus.Jump, bus.PCsrc, bus.ALUsrcA,
                      bus.ALUsrcB, bus.ResultSrc, bus.ALUop, bus.illegal, bus.trap,
                      bus.state};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.opcode = 7'b0110011;
      bus.zero = 1'b0;
      bus.mem_ready = 1'b1;
      tick();
      tick();
      total_cnt++;
      if (ctrl_vec !== 23'd0 || bus.retired !== 32'd0)
         $display("FAIL reset_outputs: ctrl=%h retired=%0d want ctrl=0 retired=0", ctrl_vec, bus.retired);
      else pass_cnt++;
   endtask

   task automatic test_r_type();
      logic [3:0] exp_st [0:4];
      exp_st[0] = 4'd1; exp_st[1] = 4'd2; exp_st[2] = 4'd7; exp_st[3] = 4'd9; exp_st[4] = 4'd1;
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         total_cnt++;
         if (bus.state !== exp_st[i] || bus.Regwrite !== (exp_st[i] == 4'd9))
            $display("FAIL r_type_seq[%0d]: state=%0d Regwrite=%b want state=%0d Regwrite=%b",
                     i, bus.state, bus.Regwrite, exp_st[i], exp_st[i] == 4'd9);
         else pass_cnt++;
         if (i == 0) begin
            total_cnt++;
            if (bus.IRwrite !== 1'b1 || bus.PCwrite !== 1'b1 || bus.Memread !== 1'b1 || bus.ALUsrcB !== 2'b10)
               $display("FAIL fetch_ctrl: IRw=%b PCw=%b Mr=%b srcB=%b want 1 1 1 10",
                        bus.IRwrite, bus.PCwrite, bus.Memread, bus.ALUsrcB);
            else pass_cnt++;
         end
         if (i == 1) begin
            total_cnt++;
            if (bus.ALUsrcA !== 2'b01 || bus.ALUsrcB !== 2'b01 || bus.illegal !== 1'b0)
               $display("FAIL decode_ctrl: srcA=%b srcB=%b illegal=%b want 01 01 0",
                        bus.ALUsrcA, bus.ALUsrcB, bus.illegal);
            else pass_cnt++;
         end
         if (i == 2) begin
            total_cnt++;
            if (bus.ALUsrcA !== 2'b10 || bus.ALUsrcB !== 2'b00 || bus.ALUop !== 2'b10)
               $display("FAIL exec_r_ctrl: srcA=%b srcB=%b op=%b want 10 00 10",
                        bus.ALUsrcA, bus.ALUsrcB, bus.ALUop);
            else pass_cnt++;
         end
      end
      total_cnt++;
      if (bus.retired !== 32'd1) $display("FAIL r_type_retired: got %0d want 1", bus.retired);
      else pass_cnt++;
   endtask

   task automatic test_load_wait();
      bus.opcode = 7'b0000011;
      tick();
      tick();
      total_cnt++;
      if (bus.state !== 4'd3 || bus.ALUsrcA !== 2'b10 || bus.ALUsrcB !== 2'b01)
         $display("FAIL memadr: state=%0d srcA=%b srcB=%b want 3 10 01", bus.state, bus.ALUsrcA, bus.ALUsrcB);
      else pass_cnt++;
      bus.mem_ready = 1'b0;
      tick();
      for (int i = 1; i <= 4; i++) begin
         if (i == 4) begin
            bus.mem_ready = 1'b1;
            #1;
         end
         total_cnt++;
         if (bus.state !== 4'd4 || bus.Memread !== 1'b1 || bus.IorD !== 1'b1)
            $display("FAIL memread_hold[%0d]: state=%0d Mr=%b IorD=%b want 4 1 1", i, bus.state, bus.Memread, bus.IorD);
         else pass_cnt++;
         tick();
      end
      total_cnt++;
      if (bus.state !== 4'd5 || bus.ResultSrc !== 2'b01 || bus.Regwrite !== 1'b1 || bus.retired !== 32'd1)
         $display("FAIL memwb: state=%0d rs=%b rw=%b retired=%0d want 5 01 1 1",
                  bus.state, bus.ResultSrc, bus.Regwrite, bus.retired);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (bus.state !== 4'd1 || bus.retired !== 32'd2)
         $display("FAIL load_retire: state=%0d retired=%0d want 1 2", bus.state, bus.retired);
      else pass_cnt++;
   endtask

   task automatic test_branch();
      logic [31:0] exp_ret;
      bus.opcode = 7'b1100011;
      for (int z = 1; z >= 0; z--) begin
         bus.zero = z[0];
         exp_ret = (z == 1) ? 32'd3 : 32'd4;
         tick();
         tick();
         total_cnt++;
         if (bus.state !== 4'd10 || bus.PCwrite !== z[0] || bus.PCsrc !== 1'b1 ||
             bus.Branch !== 1'b1 || bus.ALUop !== 2'b01)
            $display("FAIL branch_z%0d: state=%0d PCw=%b PCsrc=%b Br=%b op=%b want 10 %b 1 1 01",
                     z, bus.state, bus.PCwrite, bus.PCsrc, bus.Branch, bus.ALUop, z[0]);
         else pass_cnt++;
         tick();
         total_cnt++;
         if (bus.state !== 4'd1 || bus.retired !== exp_ret)
            $display("FAIL branch_retire_z%0d: state=%0d retired=%0d want 1 %0d", z, bus.state, bus.retired, exp_ret);
         else pass_cnt++;
      end
      bus.zero = 1'b0;
   endtask

   task automatic test_illegal_jal();
      bus.opcode = 7'b1111111;
      tick();
      total_cnt++;
      if (bus.state !== 4'd2 || bus.illegal !== 1'b1)
         $display("FAIL illegal_flag: state=%0d illegal=%b want 2 1", bus.state, bus.illegal);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (bus.state !== 4'd1 || bus.illegal !== 1'b0 || bus.retired !== 32'd4)
         $display("FAIL illegal_exit: state=%0d illegal=%b retired=%0d want 1 0 4", bus.state, bus.illegal, bus.retired);
      else pass_cnt++;
      bus.opcode = 7'b1101111;
      tick();
      tick();
      total_cnt++;
      if (bus.state !== 4'd11 || bus.Jump !== 1'b1 || bus.PCwrite !== 1'b1 ||
          bus.Regwrite !== 1'b1 || bus.ResultSrc !== 2'b10 || bus.PCsrc !== 1'b1)
         $display("FAIL jal_ctrl: state=%0d J=%b PCw=%b Rw=%b rs=%b PCsrc=%b want 11 1 1 1 10 1",
                  bus.state, bus.Jump, bus.PCwrite, bus.Regwrite, bus.ResultSrc, bus.PCsrc);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (bus.state !== 4'd1 || bus.retired !== 32'd5)
         $display("FAIL jal_retire: state=%0d retired=%0d want 1 5", bus.state, bus.retired);
      else pass_cnt++;
   endtask

   task automatic test_async_reset();
      bus.opcode = 7'b0100011;
      tick();
      tick();
      bus.mem_ready = 1'b0;
      tick();
      total_cnt++;
      if (bus.state !== 4'd6 || bus.Memwrite !== 1'b1 || bus.IorD !== 1'b1 || bus.retired !== 32'd5)
         $display("FAIL memwrite_ctrl: state=%0d Mw=%b IorD=%b retired=%0d want 6 1 1 5",
                  bus.state, bus.Memwrite, bus.IorD, bus.retired);
      else pass_cnt++;
      #1;
      rst = 1'b1;
      #1;
      total_cnt++;
      if (ctrl_vec !== 23'd0 || bus.retired !== 32'd0)
         $display("FAIL async_reset: ctrl=%h retired=%0d want ctrl=0 retired=0", ctrl_vec, bus.retired);
      else pass_cnt++;
      tick();
      rst = 1'b0;
      bus.mem_ready = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      total_cnt++;
      if (bus.state !== 4'd1 || bus.retired !== 32'd1)
         $display("FAIL store_retire: state=%0d retired=%0d want 1 1", bus.state, bus.retired);
      else pass_cnt++;
   endtask

   task automatic test_timeout();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.mem_ready = 1'b0;
      tick();
      for (int i = 1; i <= 16; i++) begin
         total_cnt++;
         if (bus.state !== 4'd1) $display("FAIL timeout_wait[%0d]: state=%0d want 1", i, bus.state);
         else pass_cnt++;
         tick();
      end
      total_cnt++;
      if (bus.state !== 4'd15 || bus.trap !== 1'b1 || bus.Memread !== 1'b0)
         $display("FAIL trap_entry: state=%0d trap=%b Mr=%b want 15 1 0", bus.state, bus.trap, bus.Memread);
      else pass_cnt++;
      bus.mem_ready = 1'b1;
      tick();
      tick();
      total_cnt++;
      if (bus.state !== 4'd15 || bus.trap !== 1'b1 || bus.retired !== 32'd0)
         $display("FAIL trap_sticky: state=%0d trap=%b retired=%0d want 15 1 0", bus.state, bus.trap, bus.retired);
      else pass_cnt++;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.mem_ready = 1'b0;
      tick();
      for (int i = 1; i <= 15; i++) tick();
      total_cnt++;
      if (bus.state !== 4'd1) $display("FAIL timeout_cycle16: state=%0d want 1", bus.state);
      else pass_cnt++;
      bus.mem_ready = 1'b1;
      tick();
      total_cnt++;
      if (bus.state !== 4'd2 || bus.trap !== 1'b0)
         $display("FAIL ready_wins: state=%0d trap=%b want 2 0", bus.state, bus.trap);
      else pass_cnt++;
   endtask

   initial begin
      pass_cnt = 0;
      total_cnt = 0;
      test_reset();
      test_r_type();
      test_load_wait();
      test_branch();
      test_illegal_jal();
      test_async_reset();
      test_timeout();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
